// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter: registered round-robin arbiter; a grant is held while its owner keeps requesting.
// Define ARB_HOLD_TIMEOUT_EN to force-release an owner after MAX_HOLD consecutive owned cycles.
module rr_hold_arbiter #(
    parameter int  NUM      = 4,
    parameter int  MAX_HOLD = 16,
    localparam int IDW      = $clog2(NUM)
) (
    input  logic           clk,
    input  logic           rst_ni,
    input  logic [NUM-1:0] req_i,
    output logic [NUM-1:0] gnt_o,
    output logic           gnt_valid_o,
    output logic [IDW-1:0] gnt_id_o,
    output logic           revoke_o
);
    typedef enum logic {IDLE, OWN} state_e;
    state_e         state_q;
    logic [NUM-1:0] gnt_q, gnt_d, rot;
    logic [IDW-1:0] id_q, id_d, ptr_q, ptr_d;
    logic           found, do_grant, expire;
    int             off, sum;

    if (NUM < 2 || MAX_HOLD < 2) begin : g_bad_params
        $error("rr_hold_arbiter: NUM and MAX_HOLD must both be >= 2");
    end

    // ptr sits just past the last owner, so that owner is scanned last and only wins when alone
    always_comb begin
        rot = NUM'({req_i, req_i} >> ptr_q);
        found = 1'b0;
        off = 0;
        for (int i = NUM - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off = i;
            end
        end
        sum = int'(ptr_q) + off;
        id_d = IDW'(sum >= NUM ? sum - NUM : sum);
        ptr_d = (id_d == IDW'(NUM - 1)) ? '0 : id_d + IDW'(1);
        gnt_d = {{(NUM-1){1'b0}}, 1'b1} << id_d;
        do_grant = found && (state_q == IDLE || !req_i[id_q]);
    end

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_q;
    logic          revoke_q;
    assign expire   = state_q == OWN && req_i[id_q] && hold_q == HW'(MAX_HOLD);
    assign revoke_o = revoke_q;
`else
    assign expire   = 1'b0;
    assign revoke_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
`ifdef ARB_HOLD_TIMEOUT_EN
            hold_q   <= '0;
            revoke_q <= 1'b0;
`endif
        end else begin
            if (do_grant) begin
                state_q <= OWN;
                gnt_q   <= gnt_d;
                id_q    <= id_d;
                ptr_q   <= ptr_d;
            end else if (state_q == OWN && (!req_i[id_q] || expire)) begin
                state_q <= IDLE;
                gnt_q   <= '0;
                id_q    <= '0;
            end
`ifdef ARB_HOLD_TIMEOUT_EN
            revoke_q <= expire;
            hold_q   <= do_grant ? HW'(1) :
                        (state_q == OWN && req_i[id_q] && !expire) ? hold_q + HW'(1) : '0;
`endif
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_valid_o = |gnt_q;
    assign gnt_id_o    = id_q;
endmodule

// File: tb/tb_rr_hold_arbiter.sv
// tb_rr_hold_arbiter: directed and randomized checks of rr_hold_arbiter against a behavioural model.
// Build with ARB_HOLD_TIMEOUT_EN to cover the forced-release behaviour.
module tb_rr_hold_arbiter;
    localparam int NUM      = 4;
    localparam int MAX_HOLD = 4;
`ifdef ARB_HOLD_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_ni = 1'b0;
    logic [NUM-1:0] req_i = '0;
    logic [NUM-1:0] gnt_o;
    logic           gnt_valid_o, revoke_o;
    logic [1:0]     gnt_id_o;
    int             n_cmp = 0, n_bad = 0;
    int             m_own = -1, m_ptr = 0, m_hold = 0, m_revd = -1, m_w;
    bit             m_rev = 1'b0;
    logic [NUM-1:0] req_edge = '0, own_oh, rnd;

    rr_hold_arbiter #(.NUM(NUM), .MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .gnt_o      (gnt_o),
        .gnt_valid_o(gnt_valid_o),
        .gnt_id_o   (gnt_id_o),
        .revoke_o   (revoke_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // First requester in round-robin order from p, skipping index x
    function automatic int pick(input logic [NUM-1:0] r, input int p, input int x);
        for (int i = 0; i < NUM; i++) begin
            int k = (p + i) % NUM;
            if (r[k] && k != x) return k;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        req_edge = req_i;
        if (!rst_ni) begin
            m_own = -1;
            m_ptr = 0;
            m_hold = 0;
            m_rev = 1'b0;
        end else if (m_own >= 0 && req_i[m_own]) begin
            m_rev = TO && m_hold == MAX_HOLD;
            if (m_rev) begin
                m_revd = m_own;
                m_own = -1;
            end else m_hold++;
        end else begin
            m_w = pick(req_i, m_ptr, m_rev ? m_revd : -1);
            if (m_w < 0) m_w = pick(req_i, m_ptr, -1);
            m_rev = 1'b0;
            m_own = m_w;
            if (m_w >= 0) begin
                m_ptr = (m_w + 1) % NUM;
                m_hold = 1;
            end
        end
        #1;
        check("gnt_o", int'(gnt_o), m_own >= 0 ? 1 << m_own : 0);
        check("gnt_valid_o", int'(gnt_valid_o), int'(m_own >= 0));
        check("gnt_id_o", int'(gnt_id_o), m_own >= 0 ? m_own : 0);
        check("revoke_o", int'(revoke_o), int'(m_rev));
        check("onehot0", int'($onehot0(gnt_o)), 1);
        check("gnt_without_req", int'(gnt_o & ~req_edge), 0);
    end

    task automatic step(input logic [NUM-1:0] r);
        req_i = r;
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string nm, input logic [NUM-1:0] r, input logic [NUM-1:0] g, input logic rv);
        step(r);
        check({nm, ".gnt"}, int'(gnt_o), int'(g));
        check({nm, ".revoke"}, int'(revoke_o), int'(rv));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not end within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step('0);
        step('0);
        rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step('0);
            check("idle.gnt", int'(gnt_o), 0);
            check("idle.valid", int'(gnt_valid_o), 0);
            check("idle.id", int'(gnt_id_o), 0);
        end
        lit("rot.first", 4'b1111, 4'b0001, 1'b0);
        for (int k = 0; k < NUM; k++) begin
            own_oh = 4'b0001 << k;
            lit("rot.hold", 4'b1111, own_oh, 1'b0);
            lit("rot.hold", 4'b1111, own_oh, 1'b0);
            lit("rot.handoff", 4'b1111 & ~own_oh, {own_oh[2:0], own_oh[3]}, 1'b0);
        end
        lit("nopre.g2", 4'b0100, 4'b0100, 1'b0);
        lit("nopre.hold", 4'b0100, 4'b0100, 1'b0);
        lit("nopre.req0", 4'b0101, 4'b0100, 1'b0);
        lit("nopre.req0", 4'b0101, 4'b0100, 1'b0);
        lit("nopre.g0", 4'b0001, 4'b0001, 1'b0);
        lit("wrap.g3", 4'b1000, 4'b1000, 1'b0);
        lit("wrap.g0", 4'b0001, 4'b0001, 1'b0);
        lit("wrap.idle", 4'b0000, 4'b0000, 1'b0);
        lit("wrap.g1", 4'b0011, 4'b0010, 1'b0);
        rst_ni = 1'b0;
        lit("rstmid.drop", 4'b0011, 4'b0000, 1'b0);
        rst_ni = 1'b1;
        lit("rstmid.g1", 4'b1010, 4'b0010, 1'b0);
        lit("to.g0", 4'b0001, 4'b0001, 1'b0);
        for (int i = 0; i < 3; i++) lit("to.hold", 4'b0011, 4'b0001, 1'b0);
        lit("to.revoke", 4'b0011, TO ? 4'b0000 : 4'b0001, TO);
        lit("to.next", 4'b0011, TO ? 4'b0010 : 4'b0001, 1'b0);
        for (int i = 0; i < 3; i++) lit("solo.hold", 4'b0010, 4'b0010, 1'b0);
        lit("solo.revoke", 4'b0010, TO ? 4'b0000 : 4'b0010, TO);
        lit("solo.regrant", 4'b0010, 4'b0010, 1'b0);
        lit("end.idle", 4'b0000, 4'b0000, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            rst_ni = $urandom_range(0, 99) != 0;
            rnd = 4'($urandom_range(0, 15));
            if (m_own >= 0 && $urandom_range(0, 3) != 0) rnd = rnd | 4'(1 << m_own);
            step(rnd);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
